// File: rtl/elastic_delay_pipe.sv
// elastic_delay_pipe: a DEPTH-stage elastic delay line with per-stage valid
// bits. It has a valid/ready handshake on both sides. Empty stages always
// accept, so bubbles collapse and the pipe holds up to DEPTH items under
// backpressure. While the consumer keeps out_ready high, latency is fixed
// at DEPTH cycles.
module elastic_delay_pipe #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int              CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Ready chain built from the output backwards: a stage may load if it is
  // empty or if the stage after it is moving this cycle.
  always_comb begin
    logic chain;
    mv    = '0;
    chain = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain = !v[i] | chain;
      mv[i] = chain;
    end
  end

  // Source of each stage: stage 0 is fed by the producer, and every other
  // stage is fed by its upstream neighbour.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  assign in_ready  = mv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Valid bits: cleared by reset or flush, otherwise advanced wherever the
  // stage is allowed to move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mv[i]) begin
          v[i] <= src_v[i];
        end
      end
    end
  end

  // Data stages: only real items are copied, so a bubble passing through
  // leaves the old data in place and avoids needless toggling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_DATA;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_DATA;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mv[i] && src_v[i]) begin
          d[i] <= src_d[i];
        end
      end
    end
  end

  // Occupancy counter: tracks the transfers at each end so that it always
  // equals the number of set valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_elastic_delay_pipe.sv
// tb_elastic_delay_pipe: directed scenarios for elastic_delay_pipe with
// WIDTH=8, DEPTH=4, RESET_DATA=8'hA5. A transfer-level FIFO model tracks
// accepted items, checks exit order and checks occupancy on every cycle.
module tb_elastic_delay_pipe;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RDATA = 8'hA5;
  localparam int         CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  int               compared;
  int               mismatched;
  bit               monitor_on;
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_item;
  logic [CNT_W-1:0] exp_cnt;

  elastic_delay_pipe #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_DATA (RDATA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Free-running clock with a 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset wipes the model along with the pipe
  always @(posedge reset) model_q.delete();

  // Transfer model: checks exit order, then applies flush or accepts input
  always @(posedge clk) begin
    if (!reset && monitor_on) begin
      if (out_valid && out_ready) begin
        compared++;
        if (model_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL order_underflow: actual=%02h required=no item", out_data);
        end else begin
          exp_item = model_q.pop_front();
          if (out_data !== exp_item) begin
            mismatched++;
            $display("[TB] FAIL order_data: actual=%02h required=%02h", out_data, exp_item);
          end
        end
      end
      if (flush) model_q.delete();
      else if (in_valid && in_ready) model_q.push_back(in_data);
    end
  end

  // Occupancy invariant, checked once per cycle away from the active edge
  always @(negedge clk) begin
    if (monitor_on && !reset) begin
      exp_cnt = CNT_W'(model_q.size());
      compared++;
      if (count !== exp_cnt) begin
        mismatched++;
        $display("[TB] FAIL count_invariant: actual=%0d required=%0d", count, exp_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_data !== RDATA || count !== 3'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_state: actual=v%b d%02h c%0d r%b required=v0 dA5 c0 r1",
               out_valid, out_data, count, in_ready);
    end
    tick(); tick();
    reset = 1'b0;
    monitor_on = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    compared++;
    if (count !== 3'd3) begin
      mismatched++;
      $display("[TB] FAIL midstream_fill: actual=%0d required=3", count);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_data !== RDATA || count !== 3'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midstream_reset: actual=v%b d%02h c%0d r%b required=v0 dA5 c0 r1",
               out_valid, out_data, count, in_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int e = 0; e < 20; e++) begin
      in_valid = (e < 16);
      in_data  = 8'(e + 1);
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL stream_ready: edge %0d actual=%b required=1", e, in_ready);
      end
      tick();
      compared++;
      if (e >= 3 && e < 19) begin
        if (out_valid !== 1'b1 || out_data !== 8'(e - 2)) begin
          mismatched++;
          $display("[TB] FAIL stream_out: edge %0d actual=v%b d%02h required=v1 d%02h",
                   e, out_valid, out_data, 8'(e - 2));
        end
      end else if (out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stream_idle: edge %0d actual=%b required=0", e, out_valid);
      end
      if (e >= 3 && e <= 15) begin
        compared++;
        if (count !== 3'd4) begin
          mismatched++;
          $display("[TB] FAIL stream_count: edge %0d actual=%0d required=4", e, count);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] items [5];
    logic [7:0] drain [4];
    items = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drain = '{8'h33, 8'h44, 8'h55, 8'h00};
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = items[k];
      #1;
      compared++;
      if (in_ready !== (k < 4)) begin
        mismatched++;
        $display("[TB] FAIL bp_ready: item %0d actual=%b required=%b", k, in_ready, k < 4);
      end
      tick();
    end
    compared++;
    if (count !== 3'd4 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      mismatched++;
      $display("[TB] FAIL bp_full: actual=c%0d v%b d%02h required=c4 v1 d11", count, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_release_ready: actual=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if (count !== 3'd4 || out_data !== 8'h22) begin
      mismatched++;
      $display("[TB] FAIL bp_release: actual=c%0d d%02h required=c4 d22", count, out_data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (out_valid !== (k < 3) || count !== 3'(3 - k) || (k < 3 && out_data !== drain[k])) begin
        mismatched++;
        $display("[TB] FAIL bp_drain: step %0d actual=v%b d%02h c%0d required=v%b d%02h c%0d",
                 k, out_valid, out_data, count, k < 3, drain[k], 3 - k);
      end
    end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'h02; tick();
    in_valid = 1'b0; tick(); tick();
    compared++;
    if (count !== 3'd2 || out_valid !== 1'b1 || out_data !== 8'h01 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bubble_compact: actual=c%0d v%b d%02h r%b required=c2 v1 d01 r1",
               count, out_valid, out_data, in_ready);
    end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    compared++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== 8'h02) begin
      mismatched++;
      $display("[TB] FAIL bubble_pulse: actual=c%0d v%b d%02h required=c1 v1 d02", count, out_valid, out_data);
    end
    out_ready = 1'b1; tick();
    compared++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL bubble_drain: actual=v%b c%0d required=v0 c0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exits [4];
    exits = '{8'hA3, 8'hA4, 8'h99, 8'h00};
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(k);
      tick();
    end
    out_ready = 1'b1; in_data = 8'h99;
    #1;
    compared++;
    if (count !== 3'd4 || in_ready !== 1'b1 || out_data !== 8'hA1) begin
      mismatched++;
      $display("[TB] FAIL full_ready: actual=c%0d r%b d%02h required=c4 r1 dA1", count, in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if (count !== 3'd4 || out_data !== 8'hA2) begin
      mismatched++;
      $display("[TB] FAIL full_simul: actual=c%0d d%02h required=c4 dA2", count, out_data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (out_valid !== (k < 3) || count !== 3'(3 - k) || (k < 3 && out_data !== exits[k])) begin
        mismatched++;
        $display("[TB] FAIL full_drain: step %0d actual=v%b d%02h c%0d required=v%b d%02h c%0d",
                 k, out_valid, out_data, count, k < 3, exits[k], 3 - k);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'hB1 + 8'(k);
      tick();
    end
    in_valid = 1'b0; tick();
    compared++;
    if (count !== 3'd3 || out_valid !== 1'b1 || out_data !== 8'hB1) begin
      mismatched++;
      $display("[TB] FAIL flush_setup: actual=c%0d v%b d%02h required=c3 v1 dB1", count, out_valid, out_data);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hC0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    compared++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== RDATA || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_clear: actual=c%0d v%b d%02h r%b required=c0 v0 dA5 r1",
               count, out_valid, out_data, in_ready);
    end
    tick(); tick(); tick(); tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_discard: actual=%b required=0", out_valid);
    end
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    compared   = 0;
    mismatched = 0;
    monitor_on = 1'b0;
    test_reset();
    test_reset_midstream();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_back_to_back();
    test_flush();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
